// File: rtl/uart_fifo_tx_pkg.sv
// Shared encodings and default baud settings for the telemetry UART transmitter.
// State names carry a TX_ prefix so they can sit beside other blocks' encodings.
package uart_fifo_tx_pkg;

  typedef enum logic [2:0] {
    TX_HOLD  = 3'd0,
    TX_IDLE  = 3'd1,
    TX_FETCH = 3'd2,
    TX_START = 3'd3,
    TX_DATA  = 3'd4,
    TX_STOP  = 3'd5
  } tx_state_e;

  // 50 MHz system clock, 9600 baud
  localparam int TX_CLKS_PER_BIT = 5208;
  localparam int TX_INIT_HOLD    = 110;
  localparam int TX_STOP_BITS    = 1;

  localparam int TX_BAUD_W = 13;
  localparam int TX_HOLD_W = 16;
  localparam int TX_BIT_W  = 3;

endpackage

// File: rtl/uart_fifo_tx.sv
// Drains a standard (non-FWFT) FIFO and serializes each byte as 8N1/8N2, LSB first.
// Read strobe to start-bit fall is one cycle; the FIFO is only read when non-empty.
module uart_fifo_tx
  import uart_fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT,
  parameter int STOP_BITS    = TX_STOP_BITS,
  parameter int INIT_HOLD    = TX_INIT_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx_data,
  output logic       busy
);

  localparam logic [TX_BAUD_W-1:0] BAUD_LAST = TX_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [TX_BAUD_W-1:0] BAUD_PRE  = TX_BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [TX_BAUD_W-1:0] BAUD_ONE  = TX_BAUD_W'(1);
  localparam logic [TX_HOLD_W-1:0] HOLD_LAST = TX_HOLD_W'((INIT_HOLD > 0) ? INIT_HOLD - 1 : 0);
  localparam logic [TX_HOLD_W-1:0] HOLD_ONE  = TX_HOLD_W'(1);
  localparam logic [TX_BIT_W-1:0]  BIT_LAST  = TX_BIT_W'(7);
  localparam logic [TX_BIT_W-1:0]  BIT_ONE   = TX_BIT_W'(1);
  localparam logic                 STOP_LAST = (STOP_BITS == 2);

  tx_state_e            state_q,    state_d;
  logic [TX_HOLD_W-1:0] hold_q,     hold_d;
  logic [TX_BAUD_W-1:0] baud_q,     baud_d;
  logic [TX_BIT_W-1:0]  bit_idx_q,  bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [7:0]           shift_q,    shift_d;
  logic                 tx_q,       tx_d;
  logic                 rd_en_q,    rd_en_d;
  logic                 busy_q,     busy_d;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      TX_HOLD: begin
        tx_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          // The strobe lands on what would have been the first idle cycle.
          if (!fifo_empty) begin
            rd_en_d = 1'b1;
            busy_d  = 1'b1;
            state_d = TX_FETCH;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      TX_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = TX_FETCH;
        end
      end

      TX_FETCH: begin
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = TX_START;
      end

      TX_START: begin
        // fifo_dout only becomes valid the cycle after the strobe, so the byte
        // is captured at the end of the start bit rather than on entry.
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = '0;
          shift_d   = fifo_dout;
          tx_d      = fifo_dout[0];
          state_d   = TX_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      TX_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_ONE;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      TX_STOP: begin
        tx_d = 1'b1;
        // Issue the next read one cycle early: the FETCH cycle doubles as the
        // final stop cycle, so back-to-back frames carry no idle gap.
        if ((stop_idx_q == STOP_LAST) && (baud_q == BAUD_PRE) && !fifo_empty) begin
          rd_en_d = 1'b1;
          baud_d  = '0;
          state_d = TX_FETCH;
        end else if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            busy_d  = 1'b0;
            state_d = TX_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        hold_d  = '0;
        state_d = TX_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_HOLD;
      hold_q     <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx_data    = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench: 1-stop and 2-stop transmitters at 4 clocks/bit, each fed by a small FIFO model.
module tb_uart_fifo_tx;

  localparam int CPB  = 4;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       empty0, empty1, rd0, rd1, tx0, tx1, busy0, busy1;
  logic [7:0] dout0 = 8'h00;
  logic [7:0] dout1 = 8'h00;
  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];
  logic [7:0] wp0 = 8'd0;
  logic [7:0] wp1 = 8'd0;
  logic [7:0] rp0 = 8'd0;
  logic [7:0] rp1 = 8'd0;
  int         viol0 = 0;
  int         viol1 = 0;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  // Standard FIFO read side: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd0) begin
      if (empty0) viol0 <= viol0 + 1;
      else begin
        dout0 <= mem0[rp0[3:0]];
        rp0   <= rp0 + 8'd1;
      end
    end
    if (rd1) begin
      if (empty1) viol1 <= viol1 + 1;
      else begin
        dout1 <= mem1[rp1[3:0]];
        rp1   <= rp1 + 8'd1;
      end
    end
  end

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .INIT_HOLD(HOLD)) u0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd0), .tx_data(tx0), .busy(busy0)
  );

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .INIT_HOLD(HOLD)) u1 (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx_data(tx1), .busy(busy1)
  );

  int   tests = 0;
  int   fails = 0;
  logic ln  [0:199];
  logic rdv [0:199];
  logic bv  [0:199];

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] exp_line;  // bit 0 = start bit, then d0..d7, then stop level(s)
    int          flen;
  } vec_t;
  vec_t vecs [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      mem0[wp0[3:0]] = d;
      wp0 = wp0 + 8'd1;
    end else begin
      mem1[wp1[3:0]] = d;
      wp1 = wp1 + 8'd1;
    end
  endtask

  // Returns the number of rising edges until the strobe is seen, or -1.
  task automatic wait_strobe(input int sel, input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0) ? rd0 : rd1) begin
        n = i + 1;
        break;
      end
    end
  endtask

  // Index 0 is the current (strobe) sample; index j is j cycles later.
  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      ln[i]  = (sel == 0) ? tx0   : tx1;
      rdv[i] = (sel == 0) ? rd0   : rd1;
      bv[i]  = (sel == 0) ? busy0 : busy1;
    end
  endtask

  task automatic check_frame(input int sel, input logic [10:0] exp, input string tag);
    int bad;
    logic e;
    for (int b = 0; b < 10 + sel; b++) begin
      bad = 0;
      e = exp[b];
      for (int c = 0; c < CPB; c++)
        if (ln[1 + CPB*b + c] !== e) bad++;
      check($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, strobes;
    logic [7:0] byte_got;

    vecs[0] = '{0, 8'h55, 11'b11010101010, 40};
    vecs[1] = '{0, 8'h00, 11'b11000000000, 40};
    vecs[2] = '{0, 8'hFF, 11'b11111111110, 40};
    vecs[3] = '{0, 8'hA5, 11'b11101001010, 40};
    vecs[4] = '{1, 8'hA3, 11'b11101000110, 44};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx0", tx0, 1);
    check("reset_rd0", rd0, 0);
    check("reset_busy0", busy0, 0);
    check("reset_tx1", tx1, 1);
    rst = 1'b0;

    // Empty FIFO: line idle, no strobe, not busy
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || rd0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    check("idle_empty_bad_cycles", bad, 0);

    // Single-byte frames
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].sel, vecs[v].data);
      wait_strobe(vecs[v].sel, 60, n);
      check($sformatf("v%0d_strobe_latency", v), n, 1);
      capture(vecs[v].sel, vecs[v].flen + 8);
      check($sformatf("v%0d_line_high_on_strobe", v), ln[0], 1);
      check_frame(vecs[v].sel, vecs[v].exp_line, $sformatf("v%0d", v));
      strobes = 0;
      for (int i = 0; i < vecs[v].flen + 8; i++) if (rdv[i] === 1'b1) strobes++;
      check($sformatf("v%0d_strobe_count", v), strobes, 1);
      check($sformatf("v%0d_busy_last", v), bv[vecs[v].flen], 1);
      check($sformatf("v%0d_busy_cleared", v), bv[vecs[v].flen + 1], 0);
    end

    // Back-to-back frames
    push(0, 8'h41);
    push(0, 8'h42);
    push(0, 8'h0D);
    wait_strobe(0, 60, n);
    check("b2b_strobe_latency", n, 1);
    capture(0, 130);
    strobes = 0;
    for (int i = 0; i < 130; i++) if (rdv[i] === 1'b1) strobes++;
    check("b2b_strobe_count", strobes, 3);
    check("b2b_strobe_at_40", rdv[40], 1);
    check("b2b_strobe_at_80", rdv[80], 1);
    check("b2b_stop_high_40", ln[40], 1);
    check("b2b_fall_41", ln[41], 0);
    check("b2b_fall_81", ln[81], 0);
    for (int f = 0; f < 3; f++) begin
      byte_got = 8'h00;
      for (int b = 0; b < 8; b++) byte_got[b] = ln[40*f + 1 + CPB*(b + 1) + 2];
      check($sformatf("b2b_byte%0d", f), byte_got, (f == 0) ? 8'h41 : (f == 1) ? 8'h42 : 8'h0D);
    end
    bad = 0;
    for (int i = 0; i <= 120; i++) if (bv[i] !== 1'b1) bad++;
    check("b2b_busy_gaps", bad, 0);
    check("b2b_busy_cleared", bv[121], 0);

    // Reset during data bit 3 of 0x00
    push(0, 8'h00);
    push(0, 8'h7E);
    wait_strobe(0, 60, n);
    check("rst_strobe_latency", n, 1);
    repeat (18) @(negedge clk);
    check("rst_line_low_in_d3", tx0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx_high", tx0, 1);
    check("rst_async_busy_low", busy0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_strobe(0, 20, n);
    check("rst_first_strobe_after_hold", n, HOLD);
    capture(0, 50);
    check_frame(0, 11'b11011111100, "rst_next");

    // FIFO fills during HOLD
    rst = 1'b1;
    push(0, 8'h3C);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_strobe(0, 20, n);
    check("hold_first_strobe", n, HOLD);
    capture(0, 50);
    check_frame(0, 11'b11001111000, "hold");

    check("no_read_when_empty0", viol0, 0);
    check("no_read_when_empty1", viol1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Transmit back end of the telemetry UART path. Drains bytes from the status-message FIFO on its read side and serializes each one onto the `tx_data` line as 8N1 (or 8N2) asynchronous serial at a fixed baud rate. Sits directly downstream of the status-message builder's FIFO and runs on the system clock, so the FIFO is clocked from `clk` on both sides.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600). Must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.
- `INIT_HOLD`, default 110: cycles the line is held idle-high after reset before the first FIFO read.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  8  FIFO read data; standard (non-FWFT) FIFO, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  one-cycle read strobe.
- `tx_data`  out  1  serial line; idles high.
- `busy`  out  1  high from the read strobe through the end of the last stop bit.

## Operation
- Reset values: `tx_data`=1, `fifo_rd_en`=0, `busy`=0; hold counter, bit counter and baud counter all cleared; state HOLD.
- **HOLD**: count `INIT_HOLD` cycles, then go to IDLE. The FIFO is never read during HOLD.
- **IDLE**: if `fifo_empty`=0, assert `fifo_rd_en` for exactly one cycle and go to FETCH. Otherwise stay in IDLE with `tx_data`=1.
- **FETCH**: latch `fifo_dout` into the shift register, drive `tx_data`=0, clear the baud counter, go to START.
- **START**: hold 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA**: drive shift[0] (LSB first) for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit 7, go to STOP.
- **STOP**: drive 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - If `fifo_empty`=0 on the final cycle, assert `fifo_rd_en` and go to FETCH, giving back-to-back frames.
  - Otherwise go to IDLE.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, and never more than once per frame.
- Baud counter is 13 bits and counts 0..`CLKS_PER_BIT`-1, wrapping to 0 at the bit boundary. Bit index is 3 bits.
- `busy` goes high on the `fifo_rd_en` cycle and low on the first IDLE cycle.
- Reset mid-frame aborts the frame immediately: line goes high, the partial byte is discarded, and the module returns to HOLD. The FIFO contents are the FIFO's own concern.

## Timing
- Latency: `fifo_empty` seen low in IDLE at cycle N → `fifo_rd_en`=1 at N → `tx_data` falls at N+1 (registered output).
- Frame length: (1 + 8 + `STOP_BITS`)×`CLKS_PER_BIT` cycles, measured from the `tx_data` fall.
- Back-to-back frames: the next start bit begins exactly one frame length after the previous one. There is no extra idle gap, because the read is overlapped with the last stop cycle.
- `tx_data`, `fifo_rd_en` and `busy` are all registered; nothing goes combinationally from inputs to outputs.
- First possible read is `INIT_HOLD` cycles after reset release.

## Structure
- Put the state encodings (HOLD, IDLE, FETCH, START, DATA, STOP) as localparams in the shared `parameters.vh` under a `TX_` prefix.
- Add baud defaults `TX_CLKS_PER_BIT` and `TX_INIT_HOLD` alongside them.
- A single module; no sub-module is needed. The baud counter stays inline.

## Test plan
- Reset with `CLKS_PER_BIT`=4, `INIT_HOLD`=3, FIFO empty → `tx_data` stays 1, `fifo_rd_en` never asserts, `busy`=0 for 200 cycles.
- One byte 0x55 queued, `CLKS_PER_BIT`=4 → single read strobe; line reads 0,1,0,1,0,1,0,1,0,1, each level 4 cycles; `busy` low 40 cycles after the fall.
- Three bytes 0x41, 0x42, 0x0D queued → three strobes spaced exactly 40 cycles apart; decoded bytes are 0x41, 0x42, 0x0D; no idle gap between frames.
- Byte 0xA3 with `STOP_BITS`=2 → stop level high for 8 cycles; frame is 44 cycles.
- Reset asserted during DATA bit 3 of 0x00 → `tx_data`=1 within the same cycle (asynchronous reset); no further strobe until `INIT_HOLD` expires and the FIFO is non-empty.
- FIFO goes non-empty during HOLD → first strobe lands exactly on the first IDLE cycle, not earlier.
